fifo_uart_tx: RTL and testbench

- Drain stage directly downstream of the `fifo` block.
- Pops one word at a time from the FIFO whenever it is non-empty.
- Serialises each word onto a single UART line: 8N1 framing, LSB first, fixed baud set by a clock-divider parameter.
- Guarantees it never pops an empty FIFO, so the FIFO's underflow flag never fires because of this stage.

---
 rtl/fifo_uart_tx.sv | 151 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO one word at a time onto an 8N1 UART line.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module fifo_uart_tx #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_SIZE-1:0] shift;
    logic [DATA_SIZE-1:0] shift_nx;
    logic                 bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                 par;
`endif

    assign bit_end  = (cnt == CNT_LAST);
    assign shift_nx = shift >> 1;

    // Frame sequencer: pop, load, then shift out start/data/(parity)/stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            fifo_pop <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            fifo_pop <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                IDLE: begin
                    tx  <= 1'b1;
                    cnt <= '0;
                    if (!fifo_empty) begin
                        state    <= POP;
                        fifo_pop <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                POP: begin
                    cnt   <= '0;
                    state <= LOAD;
                end
                LOAD: begin
                    shift <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    par   <= ^fifo_data;
`endif
                    idx   <= '0;
                    cnt   <= '0;
                    tx    <= 1'b0;
                    state <= START;
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= shift[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= shift_nx;
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx <= shift_nx[0];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_PRE) tx_done <= 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx driven by an 8-deep FIFO.
// Define FIFO_UART_TX_PARITY_EN for the parity build.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;
    logic       tx;
    logic       busy;
    logic       tx_done;

    fifo_uart_tx #(
        .DATA_SIZE   (8),
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    // 8-deep FIFO model feeding the DUT
    logic [7:0] fmem [8];
    logic [2:0] wp = 3'd0;
    logic [2:0] rp = 3'd0;
    logic [3:0] fcnt = 4'd0;
    logic       f_push = 1'b0;
    logic [7:0] f_din = 8'd0;
    logic [7:0] f_dout = 8'd0;
    logic       f_under = 1'b0;
    logic       pok;
    logic       qok;

    assign fifo_empty = (fcnt == 4'd0);
    assign fifo_data  = f_dout;
    assign pok = f_push && (fcnt != 4'd8);
    assign qok = fifo_pop && (fcnt != 4'd0);

    always @(posedge clk) begin
        if (pok) begin
            fmem[wp] <= f_din;
            wp <= wp + 3'd1;
        end
        if (fifo_pop && !qok) f_under <= 1'b1;
        if (qok) begin
            f_dout <= fmem[rp];
            rp <= rp + 3'd1;
        end
        fcnt <= fcnt + {3'b000, pok} - {3'b000, qok};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   pop_cnt = 0;
    int   dbl = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic prev_pop = 1'b0;

    always @(negedge clk) begin
        if (tx_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (fifo_pop) begin
            pop_cnt = pop_cnt + 1;
            if (prev_pop) dbl = dbl + 1;
        end
        prev_pop = fifo_pop;
    end

    int   checks = 0;
    int   errors = 0;
    logic samp [FL];

    task automatic push(input logic [7:0] v, output int pc);
        f_push = 1'b1;
        f_din  = v;
        @(negedge clk);
        f_push = 1'b0;
        pc = cyc;
    endtask

    task automatic recv(output logic [7:0] d, output logic p,
                        output int s, output bit to);
        int n;
        n = 0;
        d = 8'd0;
        p = 1'b0;
        s = 0;
        to = 1'b0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            to = 1'b1;
            return;
        end
        s = cyc;
        for (int i = 0; i < FL; i++) begin
            samp[i] = tx;
            @(negedge clk);
        end
        for (int b = 0; b < 8; b++) d[b] = samp[(b + 1) * CPB + CPB / 2];
        p = samp[9 * CPB + CPB / 2];
    endtask

    task automatic test_reset();
        int btx, bbusy, bpop;
        btx = 0; bbusy = 0; bpop = 0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("FAIL rst_tx got %b want 1", tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy got %b want 0", busy);
        end
        checks++;
        if (fifo_pop !== 1'b0) begin
            errors++; $display("FAIL rst_pop got %b want 0", fifo_pop);
        end
        checks++;
        if (tx_done !== 1'b0) begin
            errors++; $display("FAIL rst_done got %b want 0", tx_done);
        end
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) btx++;
            if (busy !== 1'b0) bbusy++;
            if (fifo_pop !== 1'b0) bpop++;
        end
        checks++;
        if (btx !== 0) begin
            errors++; $display("FAIL idle_tx bad cycles %0d want 0", btx);
        end
        checks++;
        if (bbusy !== 0) begin
            errors++; $display("FAIL idle_busy bad cycles %0d want 0", bbusy);
        end
        checks++;
        if (bpop !== 0) begin
            errors++; $display("FAIL idle_pop bad cycles %0d want 0", bpop);
        end
    endtask

    task automatic test_single();
        int p0, d0, pc, s, bad;
        logic [7:0] d;
        logic p;
        bit to;
`ifdef FIFO_UART_TX_PARITY_EN
        logic [NB-1:0] exp_seq = 11'b10101001010;
`else
        logic [NB-1:0] exp_seq = 10'b1101001010;
`endif
        p0 = pop_cnt;
        d0 = done_cnt;
        push(8'hA5, pc);
        recv(d, p, s, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL single_timeout got none want frame");
            return;
        end
        checks++;
        if (s !== pc + 3) begin
            errors++; $display("FAIL single_latency got %0d want %0d", s - pc, 3);
        end
        for (int b = 0; b < NB; b++) begin
            bad = 0;
            for (int k = 0; k < CPB; k++)
                if (samp[b * CPB + k] !== exp_seq[b]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL single_bit%0d got %0d wrong cycles want %b",
                         b, bad, exp_seq[b]);
            end
        end
        checks++;
        if (d !== 8'hA5) begin
            errors++; $display("FAIL single_data got %h want a5", d);
        end
        checks++;
        if (pop_cnt - p0 !== 1) begin
            errors++; $display("FAIL single_pops got %0d want 1", pop_cnt - p0);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++; $display("FAIL single_done got %0d want 1", done_cnt - d0);
        end
        checks++;
        if (done_cyc - s + 1 !== FL) begin
            errors++;
            $display("FAIL single_done_cyc got %0d want %0d", done_cyc - s + 1, FL);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_busy_end got %b want 0", busy);
        end
    endtask

    task automatic test_drain();
        logic [7:0] d [8];
        int s [8];
        bit to [8];
        int p0;
        logic p;
        p0 = pop_cnt;
        fork
            begin
                int pc;
                for (int i = 0; i < 8; i++) push(8'(i), pc);
            end
            begin
                for (int k = 0; k < 8; k++) recv(d[k], p, s[k], to[k]);
            end
        join
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (to[k] || d[k] !== 8'(k)) begin
                errors++;
                $display("FAIL drain_data%0d got %h to=%0d want %h", k, d[k], to[k], k);
            end
        end
        for (int k = 1; k < 8; k++) begin
            checks++;
            if (s[k] - s[k - 1] !== FL + 3) begin
                errors++;
                $display("FAIL drain_gap%0d got %0d want 3", k, s[k] - s[k - 1] - FL);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_empty !== 1'b1) begin
            errors++; $display("FAIL drain_empty got %b want 1", fifo_empty);
        end
        checks++;
        if (f_under !== 1'b0) begin
            errors++; $display("FAIL drain_underflow got %b want 0", f_under);
        end
        checks++;
        if (pop_cnt - p0 !== 8) begin
            errors++; $display("FAIL drain_pops got %0d want 8", pop_cnt - p0);
        end
        checks++;
        if (dbl !== 0) begin
            errors++; $display("FAIL pop_twice got %0d want 0", dbl);
        end
    endtask

    task automatic test_push_during();
        logic [7:0] a, b;
        logic p;
        int sa, sb;
        bit ta, tb;
        fork
            begin
                int pc;
                push(8'h3C, pc);
                repeat (20) @(negedge clk);
                push(8'hC3, pc);
            end
            begin
                recv(a, p, sa, ta);
                recv(b, p, sb, tb);
            end
        join
        checks++;
        if (ta || a !== 8'h3C) begin
            errors++; $display("FAIL pdt_first got %h want 3c", a);
        end
        checks++;
        if (tb || b !== 8'hC3) begin
            errors++; $display("FAIL pdt_second got %h want c3", b);
        end
        checks++;
        if (sb - sa !== FL + 3) begin
            errors++; $display("FAIL pdt_gap got %0d want 3", sb - sa - FL);
        end
    endtask

    task automatic test_mid_reset();
        int pc, n, p0, s;
        logic [7:0] d;
        logic p;
        bit to;
        p0 = pop_cnt;
        push(8'h52, pc);
        push(8'h96, pc);
        n = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++; $display("FAIL mr_start got %b want 0", tx);
            return;
        end
        repeat (17) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++; $display("FAIL mr_bit3 got %b want 0", tx);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++; $display("FAIL mr_tx got %b want 1", tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL mr_busy got %b want 0", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        recv(d, p, s, to);
        checks++;
        if (to || d !== 8'h96) begin
            errors++; $display("FAIL mr_next got %h want 96", d);
        end
        checks++;
        if (pop_cnt - p0 !== 2) begin
            errors++; $display("FAIL mr_pops got %0d want 2", pop_cnt - p0);
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] a, b;
        logic pa, pb;
        int sa, sb;
        bit ta, tb;
        fork
            begin
                int pc;
                push(8'h07, pc);
                push(8'h03, pc);
            end
            begin
                recv(a, pa, sa, ta);
                recv(b, pb, sb, tb);
            end
        join
        checks++;
        if (ta || a !== 8'h07 || pa !== 1'b1) begin
            errors++; $display("FAIL par_07 got %h/%b want 07/1", a, pa);
        end
        checks++;
        if (tb || b !== 8'h03 || pb !== 1'b0) begin
            errors++; $display("FAIL par_03 got %h/%b want 03/0", b, pb);
        end
        checks++;
        if (done_cyc - sb + 1 !== 44) begin
            errors++; $display("FAIL par_len got %0d want 44", done_cyc - sb + 1);
        end
        checks++;
        if (sb - sa !== 47) begin
            errors++; $display("FAIL par_gap got %0d want 3", sb - sa - 44);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_drain();
        test_push_during();
        test_mid_reset();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
